// File: rtl/led_frame_scheduler.sv
// led_frame_scheduler
// Double-buffered 16x16 red/green frame store between game logic and the LED
// display driver. Pixel writes and clears go to the back buffer. Buffers swap
// only on a display frame wrap, so the panel never shows a torn frame. The block
// also produces the driver's row-advance enable and mirrors the scanned row.
// Optional build macro: LED_TEST_PATTERN_EN adds a test_pat input that overrides
// the pixel outputs with a fixed checkerboard.
module led_frame_scheduler #(
   parameter int TICK_DIV    = 4,
   parameter int DRV_FREQDIV = 0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              wr_en,
   input  logic [3:0]        wr_row,
   input  logic [3:0]        wr_col,
   input  logic              wr_red,
   input  logic              wr_grn,
   output logic              wr_ready,
   input  logic              clr,
   input  logic              swap_req,
   output logic              swap_ack,
   output logic              busy,
   output logic              scan_en,
   output logic [3:0]        row_sel,
   output logic              frame_tick,
`ifdef LED_TEST_PATTERN_EN
   input  logic              test_pat,
`endif
   output logic [15:0][15:0] red_pixels,
   output logic [15:0][15:0] grn_pixels
);

   localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = DRV_FREQDIV + 4;
   localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST = {SW{1'b1}};
   localparam logic [15:0]   ROW_ZERO  = 16'h0000;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_CLEARING  = 2'd1;
   localparam logic [1:0] ST_SWAP_WAIT = 2'd2;

   logic [DW-1:0]              div_cnt_q;
   logic [SW-1:0]              scan_cnt_q;
   logic                       scan_en_q;
   logic                       frame_tick_q;
   logic                       frame_end_s;

   logic [1:0]                 state_q, state_d;
   logic [3:0]                 clr_row_q, clr_row_d;
   logic                       front_sel_q, front_sel_d;
   logic                       swap_ack_q, swap_ack_d;
   logic [1:0][15:0][15:0]     red_q, red_d;
   logic [1:0][15:0][15:0]     grn_q, grn_d;
   logic                       back_s;

   // A frame ends on the scan pulse that wraps the scan counter.
   assign frame_end_s = scan_en_q & (scan_cnt_q == SCAN_LAST);
   assign back_s      = ~front_sel_q;

   // Scan timing: divider, row-advance enable, scan counter and frame tick.
   always_ff @(posedge CLK) begin
      if (RST) begin
         div_cnt_q    <= {DW{1'b0}};
         scan_en_q    <= 1'b0;
         scan_cnt_q   <= {SW{1'b0}};
         frame_tick_q <= 1'b0;
      end else begin
         div_cnt_q    <= (div_cnt_q == DIV_LAST) ? {DW{1'b0}} : div_cnt_q + DW'(1);
         scan_en_q    <= (div_cnt_q == DIV_LAST);
         scan_cnt_q   <= scan_cnt_q + SW'(scan_en_q);
         frame_tick_q <= frame_end_s;
      end
   end

   // Next-state logic for the control FSM and both frame buffers.
   always_comb begin
      state_d     = state_q;
      clr_row_d   = clr_row_q;
      front_sel_d = front_sel_q;
      swap_ack_d  = 1'b0;
      red_d       = red_q;
      grn_d       = grn_q;
      case (state_q)
         ST_IDLE: begin
            if (clr) begin
               // Clear wins over a same-cycle write and swap request.
               state_d   = ST_CLEARING;
               clr_row_d = 4'd0;
            end else begin
               if (wr_en) begin
                  red_d[back_s][wr_row][wr_col] = wr_red;
                  grn_d[back_s][wr_row][wr_col] = wr_grn;
               end else begin
                  red_d = red_q;
               end
               if (swap_req) begin
                  state_d = ST_SWAP_WAIT;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_CLEARING: begin
            red_d[back_s][clr_row_q] = ROW_ZERO;
            grn_d[back_s][clr_row_q] = ROW_ZERO;
            if (clr_row_q == 4'd15) begin
               state_d = ST_IDLE;
            end else begin
               clr_row_d = clr_row_q + 4'd1;
            end
         end
         ST_SWAP_WAIT: begin
            // Only a frame end seen while already waiting may swap.
            if (frame_end_s) begin
               front_sel_d = ~front_sel_q;
               swap_ack_d  = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_SWAP_WAIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control state and frame storage registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         clr_row_q   <= 4'd0;
         front_sel_q <= 1'b0;
         swap_ack_q  <= 1'b0;
         red_q       <= '0;
         grn_q       <= '0;
      end else begin
         state_q     <= state_d;
         clr_row_q   <= clr_row_d;
         front_sel_q <= front_sel_d;
         swap_ack_q  <= swap_ack_d;
         red_q       <= red_d;
         grn_q       <= grn_d;
      end
   end

   // Pixel planes come straight from the front buffer (optionally overridden).
   always_comb begin
`ifdef LED_TEST_PATTERN_EN
      if (test_pat) begin
         for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
               red_pixels[r][c] = ~(r[0] ^ c[0]);
               grn_pixels[r][c] = r[0] ^ c[0];
            end
         end
      end else begin
         red_pixels = red_q[front_sel_q];
         grn_pixels = grn_q[front_sel_q];
      end
`else
      red_pixels = red_q[front_sel_q];
      grn_pixels = grn_q[front_sel_q];
`endif
   end

   assign wr_ready   = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign swap_ack   = swap_ack_q;
   assign scan_en    = scan_en_q;
   assign frame_tick = frame_tick_q;
   assign row_sel    = scan_cnt_q[DRV_FREQDIV+3 -: 4];

endmodule
